// File: rtl/serial_sub_pkg.sv
// Shared types and limits for the bit-serial subtract controller.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sub_state_e;

  localparam int SUB_WIDTH_MIN = 2;
  localparam int SUB_WIDTH_MAX = 64;

endpackage

// File: rtl/full_sub.sv
// 1-bit full subtractor: d = a - b - c, bo is the borrow out.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ c;
  assign bo = (~a & (b | c)) | (b & c);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b - bin, LSB first, through one full_sub cell.
// Result and final borrow are registered and only change on entry to DONE.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  if (WIDTH < SUB_WIDTH_MIN || WIDTH > SUB_WIDTH_MAX) begin : g_bad_width
    $error("serial_sub_ctrl: WIDTH %0d outside legal range", WIDTH);
  end

  sub_state_e       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic             borrow;
  logic [CNT_W-1:0] cnt;
  logic             cell_d;
  logic             cell_bo;

  full_sub u_cell (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .c  (borrow),
    .d  (cell_d),
    .bo (cell_bo)
  );

  // The last RUN cycle writes the completed word straight into diff, so
  // the visible outputs never see a partially shifted value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      borrow  <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr    <= a;
            b_sr    <= b;
            borrow  <= bin;
            diff_sr <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          diff_sr <= {cell_d, diff_sr[WIDTH-1:1]};
          borrow  <= cell_bo;
          if (cnt == LAST_BIT) begin
            diff  <= {cell_d, diff_sr[WIDTH-1:1]};
            bout  <= cell_bo;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Randomized self-checking bench for serial_sub_ctrl at WIDTH=8 and WIDTH=2.
module tb_serial_sub_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       bin8;
  logic       busy8;
  logic       done8;
  logic [7:0] diff8;
  logic       bout8;
  logic       start2;
  logic [1:0] a2;
  logic [1:0] b2;
  logic       bin2;
  logic       busy2;
  logic       done2;
  logic [1:0] diff2;
  logic       bout2;

  int check_count = 0;
  int pass_count  = 0;

  serial_sub_ctrl #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .bin   (bin8),
    .busy  (busy8),
    .done  (done8),
    .diff  (diff8),
    .bout  (bout8)
  );

  serial_sub_ctrl #(.WIDTH(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start2),
    .a     (a2),
    .b     (b2),
    .bin   (bin2),
    .busy  (busy2),
    .done  (done2),
    .diff  (diff2),
    .bout  (bout2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain signed integer subtraction, wrapped to wd bits.
  function automatic void ref_sub(input int wd, input longint ta, input longint tb,
                                  input longint tbin, output longint rd, output bit rb);
    longint r;
    r  = ta - tb - tbin;
    rb = (r < 0);
    rd = (r + (longint'(1) << wd)) % (longint'(1) << wd);
  endfunction

  // Drives one WIDTH=8 operation and collects what the DUT produced.
  task automatic do_op8(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                        output logic [7:0] rd, output logic rb, output int edges,
                        output bit moved, output bit timed_out);
    logic [7:0] held;
    @(negedge clk);
    a8 = ta; b8 = tb; bin8 = tbin; start8 = 1'b1;
    held = diff8;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    edges = 0; moved = 0; timed_out = 1;
    while (edges < 40) begin
      if (done8) begin
        timed_out = 0;
        break;
      end
      if (diff8 !== held) moved = 1;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    rd = diff8;
    rb = bout8;
  endtask

  task automatic do_op2(input logic [1:0] ta, input logic [1:0] tb, input logic tbin,
                        output logic [1:0] rd, output logic rb, output bit timed_out);
    int n;
    @(negedge clk);
    a2 = ta; b2 = tb; bin2 = tbin; start2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
    n = 0; timed_out = 1;
    while (n < 20) begin
      if (done2) begin
        timed_out = 0;
        break;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    rd = diff2;
    rb = bout2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start8 = 1'b0; a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0;
    start2 = 1'b0; a2 = 2'b11; b2 = 2'b00; bin2 = 1'b0;
    repeat (3) @(negedge clk);
    check_count++;
    if ({busy8, done8, diff8, bout8} !== 11'd0) $display("[TB] FAIL reset8 got %h exp 0", {busy8, done8, diff8, bout8});
    else pass_count++;
    check_count++;
    if ({busy2, done2, diff2, bout2} !== 5'd0) $display("[TB] FAIL reset2 got %h exp 0", {busy2, done2, diff2, bout2});
    else pass_count++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [7:0] ta[3] = '{8'h5A, 8'h00, 8'h10};
    logic [7:0] tb[3] = '{8'h3C, 8'h01, 8'h10};
    logic       tc[3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] xd[3] = '{8'h1E, 8'hFF, 8'hFF};
    logic       xb[3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] rd; logic rb; int edges; bit moved, to;
    for (int i = 0; i < 3; i++) begin
      do_op8(ta[i], tb[i], tc[i], rd, rb, edges, moved, to);
      check_count++;
      if (to || edges != 8) $display("[TB] FAIL directed_latency[%0d] got %0d edges exp 8", i, edges);
      else pass_count++;
      check_count++;
      if (rd !== xd[i] || rb !== xb[i]) $display("[TB] FAIL directed_result[%0d] got %h/%b exp %h/%b", i, rd, rb, xd[i], xb[i]);
      else pass_count++;
      check_count++;
      if (moved) $display("[TB] FAIL directed_hold[%0d] diff changed during RUN got 1 exp 0", i);
      else pass_count++;
    end
  endtask

  task automatic test_ignore_start();
    int done_cnt = 0;
    int done_edge = -1;
    int busy_fall = -1;
    logic [7:0] rd = 8'h00; logic rb = 1'b1;
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    for (int e = 1; e <= 22; e++) begin
      if (e == 3) begin
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      if (done8) begin
        done_cnt++;
        done_edge = e;
        rd = diff8;
        rb = bout8;
      end
      if (!busy8 && busy_fall < 0) busy_fall = e;
      if (busy8 && busy_fall >= 0) busy_fall = 100;
    end
    check_count++;
    if (done_cnt != 1 || done_edge != 8) $display("[TB] FAIL ignore_done got %0d pulses at %0d exp 1 at 8", done_cnt, done_edge);
    else pass_count++;
    check_count++;
    if (rd !== 8'h7F || rb !== 1'b0) $display("[TB] FAIL ignore_result got %h/%b exp 7f/0", rd, rb);
    else pass_count++;
    check_count++;
    if (busy_fall != 9) $display("[TB] FAIL ignore_busy got fall %0d exp 9", busy_fall);
    else pass_count++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] oa[30]; logic [7:0] ob[30]; logic oc[30];
    logic [7:0] prev;
    longint ed; bit eb; bit exp_done;
    int fails_before;
    repeat (2) @(negedge clk);
    prev = diff8;
    for (int k = 0; k < 30; k++) begin
      oa[k] = 8'($urandom); ob[k] = 8'($urandom); oc[k] = 1'($urandom);
      a8 = oa[k]; b8 = ob[k]; bin8 = oc[k]; start8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      exp_done = ((k % 10) == 8);
      check_count++;
      if (done8 !== exp_done) $display("[TB] FAIL b2b_done[%0d] got %b exp %b", k, done8, exp_done);
      else pass_count++;
      if (exp_done) begin
        ref_sub(8, longint'(oa[k-8]), longint'(ob[k-8]), longint'(oc[k-8]), ed, eb);
        check_count++;
        if (diff8 !== 8'(ed) || bout8 !== eb) $display("[TB] FAIL b2b_result[%0d] got %h/%b exp %h/%b", k, diff8, bout8, 8'(ed), eb);
        else pass_count++;
        prev = 8'(ed);
      end else begin
        fails_before = check_count - pass_count;
        check_count++;
        if (diff8 !== prev) $display("[TB] FAIL b2b_stable[%0d] got %h exp %h", k, diff8, prev);
        else pass_count++;
        if (check_count - pass_count != fails_before) prev = diff8;
      end
    end
    start8 = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [7:0] rd; logic rb; int edges; bit moved, to;
    longint ed; bit eb; int seen = 0;
    logic [7:0] ta, tb; logic tc;
    do_op8(8'h33, 8'h11, 1'b0, rd, rb, edges, moved, to);
    @(negedge clk);
    a8 = 8'hC3; b8 = 8'h12; bin8 = 1'b1; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check_count++;
    if ({busy8, done8, diff8, bout8} !== 11'd0) $display("[TB] FAIL midreset_clear got %h exp 0", {busy8, done8, diff8, bout8});
    else pass_count++;
    repeat (3) begin
      @(negedge clk);
      if (done8) seen++;
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (done8) seen++;
    end
    check_count++;
    if (seen != 0) $display("[TB] FAIL midreset_nodone got %0d pulses exp 0", seen);
    else pass_count++;
    ta = 8'($urandom); tb = 8'($urandom); tc = 1'($urandom);
    do_op8(ta, tb, tc, rd, rb, edges, moved, to);
    ref_sub(8, longint'(ta), longint'(tb), longint'(tc), ed, eb);
    check_count++;
    if (to || rd !== 8'(ed) || rb !== eb) $display("[TB] FAIL midreset_after got %h/%b exp %h/%b", rd, rb, 8'(ed), eb);
    else pass_count++;
  endtask

  task automatic test_random();
    logic [7:0] rd; logic rb; int edges; bit moved, to;
    longint ed; bit eb;
    logic [7:0] ta, tb; logic tc;
    for (int i = 0; i < 24; i++) begin
      ta = 8'($urandom); tb = 8'($urandom); tc = 1'($urandom);
      if (i == 0) begin ta = 8'hFF; tb = 8'hFF; tc = 1'b1; end
      if (i == 1) begin ta = 8'h00; tb = 8'hFF; tc = 1'b1; end
      do_op8(ta, tb, tc, rd, rb, edges, moved, to);
      ref_sub(8, longint'(ta), longint'(tb), longint'(tc), ed, eb);
      check_count++;
      if (to || edges != 8 || moved || rd !== 8'(ed) || rb !== eb)
        $display("[TB] FAIL random[%0d] got %h/%b edges %0d exp %h/%b edges 8", i, rd, rb, edges, 8'(ed), eb);
      else pass_count++;
    end
  endtask

  task automatic test_width2_sweep();
    logic [1:0] rd; logic rb; bit to;
    longint ed; bit eb;
    logic [4:0] v;
    for (int i = 0; i < 32; i++) begin
      v = 5'(i);
      do_op2(v[4:3], v[2:1], v[0], rd, rb, to);
      ref_sub(2, longint'(v[4:3]), longint'(v[2:1]), longint'(v[0]), ed, eb);
      check_count++;
      if (to || rd !== 2'(ed) || rb !== eb)
        $display("[TB] FAIL w2[%0d] got %h/%b exp %h/%b", i, rd, rb, 2'(ed), eb);
      else pass_count++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_width2_sweep();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
